// File: rtl/mam_ahb3_pkg.sv
// mam_ahb3_pkg: AHB3 transfer/burst encodings and FSM states for the MAM AHB3 master
package mam_ahb3_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    typedef enum logic [2:0] {S_IDLE, S_LOCK, S_ADDR, S_DATA, S_DONE} state_t;
endpackage

// File: rtl/mam_ahb3_if.sv
// mam_ahb3_if: AHB3 master turning MAM debug memory requests into locked, non-pipelined AHB3 transfers
module mam_ahb3_if
    import mam_ahb3_pkg::*;
#(
    parameter int PLEN        = 32,
    parameter int XLEN        = 32,
    parameter int BEATS_W     = 16,
    parameter int LOCK_CYCLES = 2,
    parameter int HPROT       = 'h3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic               req_burst,
    input  logic [BEATS_W-1:0] req_beats,
    input  logic [PLEN-1:0]    req_addr,
    input  logic               write_valid,
    input  logic [XLEN-1:0]    write_data,
    output logic               write_ready,
    output logic               read_valid,
    output logic [XLEN-1:0]    read_data,
    input  logic               read_ready,
    output logic               err_o,
    output logic               ahb3_hsel_o,
    output logic [PLEN-1:0]    ahb3_haddr_o,
    output logic [XLEN-1:0]    ahb3_hwdata_o,
    output logic               ahb3_hwrite_o,
    output logic [2:0]         ahb3_hsize_o,
    output logic [2:0]         ahb3_hburst_o,
    output logic [XLEN/8-1:0]  ahb3_hprot_o,
    output logic [1:0]         ahb3_htrans_o,
    output logic               ahb3_hmastlock_o,
    input  logic [XLEN-1:0]    ahb3_hrdata_i,
    input  logic               ahb3_hready_i,
    input  logic               ahb3_hresp_i
);
    localparam int SW = XLEN / 8;

    state_t             state_q, state_d;
    logic [PLEN-1:0]    addr_q, addr_d;
    logic [BEATS_W-1:0] cnt_q, cnt_d;
    logic [7:0]         lock_q, lock_d;
    logic               we_q, we_d, burst_q, burst_d, first_q, first_d;
    logic               errm_q, errm_d, err_q, err_d, rvalid_q, rvalid_d;
    logic [XLEN-1:0]    wdata_q, wdata_d, rdata_q, rdata_d;
    logic               data_ok, last;

    always_comb begin
        data_ok       = we_q ? write_valid : !rvalid_q;
        last          = cnt_q == BEATS_W'(1);
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        lock_d        = lock_q;
        we_d          = we_q;
        burst_d       = burst_q;
        first_d       = first_q;
        errm_d        = errm_q;
        err_d         = 1'b0;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        rvalid_d      = rvalid_q && !read_ready;
        write_ready   = 1'b0;
        ahb3_htrans_o = HTRANS_IDLE;
        case (state_q)
            S_IDLE: if (req_valid) begin
                addr_d  = req_addr;
                we_d    = req_we;
                burst_d = req_burst;
                cnt_d   = (req_burst && req_beats != '0) ? req_beats : BEATS_W'(1);
                lock_d  = '0;
                first_d = 1'b1;
                errm_d  = 1'b0;
                state_d = S_LOCK;
            end
            S_LOCK: begin
                lock_d  = lock_q + 8'd1;
                state_d = (lock_q == 8'(LOCK_CYCLES - 1)) ? S_ADDR : S_LOCK;
            end
            S_ADDR: if (errm_q) begin
                // after an error the remaining beats are drained locally, never on the bus
                write_ready = we_q && write_valid;
                if (data_ok) begin
                    rvalid_d = !we_q;
                    rdata_d  = we_q ? rdata_q : '0;
                    cnt_d    = cnt_q - BEATS_W'(1);
                    state_d  = last ? S_DONE : S_ADDR;
                end
            end else begin
                ahb3_htrans_o = data_ok ? ((first_q || addr_q[9:0] == '0) ? HTRANS_NONSEQ : HTRANS_SEQ)
                                        : ((burst_q && !first_q) ? HTRANS_BUSY : HTRANS_IDLE);
                if (data_ok && ahb3_hready_i) begin
                    write_ready = we_q;
                    wdata_d     = we_q ? write_data : wdata_q;
                    first_d     = 1'b0;
                    state_d     = S_DATA;
                end
            end
            S_DATA: begin
                ahb3_htrans_o = (burst_q && !last) ? HTRANS_BUSY : HTRANS_IDLE;
                if (ahb3_hready_i) begin
                    rvalid_d = !we_q;
                    rdata_d  = we_q ? rdata_q : (ahb3_hresp_i ? '0 : ahb3_hrdata_i);
                    err_d    = ahb3_hresp_i;
                    errm_d   = ahb3_hresp_i;
                    cnt_d    = cnt_q - BEATS_W'(1);
                    addr_d   = addr_q + PLEN'(SW);
                    state_d  = last ? S_DONE : S_ADDR;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            lock_q   <= '0;
            we_q     <= 1'b0;
            burst_q  <= 1'b0;
            first_q  <= 1'b0;
            errm_q   <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            lock_q   <= lock_d;
            we_q     <= we_d;
            burst_q  <= burst_d;
            first_q  <= first_d;
            errm_q   <= errm_d;
            err_q    <= err_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign req_ready        = state_q == S_IDLE;
    assign read_valid       = rvalid_q;
    assign read_data        = rdata_q;
    assign err_o            = err_q;
    assign ahb3_hsel_o      = state_q inside {S_LOCK, S_ADDR, S_DATA};
    assign ahb3_hmastlock_o = ahb3_hsel_o;
    assign ahb3_haddr_o     = addr_q;
    assign ahb3_hwdata_o    = wdata_q;
    assign ahb3_hwrite_o    = we_q;
    assign ahb3_hburst_o    = burst_q ? HBURST_INCR : HBURST_SINGLE;
    assign ahb3_hsize_o     = 3'($clog2(SW));
    assign ahb3_hprot_o     = SW'(HPROT);
endmodule
